prm_sweep_ctrl: RTL
===================

PRM_SWEEP_CTRL -- requirements
Module: prm_sweep_ctrl

Interface
REQ-001 Parameter XW, default 4, x-coordinate width.
REQ-002 Parameter YW, default 5, y-coordinate width.
REQ-003 Parameter ZW, default 5, z-coordinate width; N = XW+YW+ZW.
REQ-004 Parameter LAT, default 2, range 1..8, cycles from xyzInput drive to matching result_imp.
REQ-005 Port CLK  in  1  single clock; all logic on rising edge.
REQ-006 Port RST  in  1  reset, synchronous, active-high.
REQ-007 Port start  in  1  sampled in IDLE only; begins a sweep.
REQ-008 Port abort  in  1  terminates the sweep in progress.
REQ-009 Port sel1_cfg  in  3  checker select 1, latched at start.
REQ-010 Port sel2_cfg  in  8  checker select 2, latched at start.
REQ-011 Port result_imp  in  32  checker result; nonzero = hit.
REQ-012 Port xyzInput  out  N  swept coordinate {x,y,z} to the checker.
REQ-013 Port sel1  out  3  latched sel1_cfg.
REQ-014 Port sel2  out  8  latched sel2_cfg.
REQ-015 Port busy  out  1  high in RUN and DRAIN.
REQ-016 Port done  out  1  one-cycle pulse at sweep completion.
REQ-017 Port hit_cnt  out  N+1  number of hit points in current/last sweep.
REQ-018 Port first_hit  out  N  coordinate of the first hit.
REQ-019 Port first_hit_vld  out  1  first_hit is valid.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-021 IDLE->RUN on start=1 and abort=0; same edge latches sel1/sel2, clears hit_cnt, first_hit, first_hit_vld and sets xyzInput=0.
REQ-022 In RUN xyzInput SHALL increment by 1 per cycle, from 0 through 2^N-1, each value held one cycle.
REQ-023 RUN->DRAIN on the edge after xyzInput=2^N-1 is driven; xyzInput then holds 2^N-1.
REQ-024 A LAT-deep tag pipeline (valid bit + coordinate) SHALL align each issued coordinate with result_imp LAT cycles later.
REQ-025 Pipeline valid is set only for coordinates driven in RUN.
REQ-026 When the tag output is valid and result_imp!=0, hit_cnt SHALL increment by 1 (width N+1, never wraps).
REQ-027 On the first such hit, first_hit SHALL capture the tag coordinate and first_hit_vld SHALL set; later hits leave both unchanged.
REQ-028 DRAIN lasts exactly LAT cycles, then DONE; DONE lasts one cycle (done=1), then IDLE.
REQ-029 done SHALL rise exactly 1+2^N+LAT cycles after the edge on which start is sampled.
REQ-030 start while not in IDLE SHALL be ignored.
REQ-031 abort=1 in RUN or DRAIN SHALL force IDLE next edge, clear pipeline valids, suppress done, and hold hit_cnt/first_hit at partial values.
REQ-032 abort and start both high in IDLE: abort wins, no sweep starts.
REQ-033 sel1/sel2 SHALL remain stable from start through DONE and hold in IDLE.
REQ-034 hit_cnt, first_hit and first_hit_vld SHALL hold in IDLE until the next accepted start.

Reset
REQ-035 RST=1 SHALL force IDLE and set xyzInput=0, sel1=0, sel2=0, busy=0, done=0, hit_cnt=0, first_hit=0, first_hit_vld=0, all pipeline valids 0.
REQ-036 RST SHALL take priority over start and abort, including mid-sweep; no done pulse follows.

Verification (XW=YW=ZW=1, N=3, LAT=2)
REQ-037 start at cycle 0, result_imp=0 always -> xyzInput 0..7 on cycles 1..8, busy cycles 1..10, done=1 at cycle 11, hit_cnt=0, first_hit_vld=0.
REQ-038 result_imp nonzero exactly when the aligned tag is 3 or 6 -> hit_cnt=2, first_hit=3, first_hit_vld=1 at done.
REQ-039 result_imp=32'hFFFFFFFF always -> hit_cnt=8 (4'b1000), first_hit=0.
REQ-040 abort at cycle 4 with result_imp always nonzero -> IDLE at cycle 5, busy=0, done never pulses, hit_cnt=1 (only tag 0 sampled).
REQ-041 start pulsed at cycle 3 during a sweep, and start+abort together in IDLE -> both ignored; single done at cycle 11 only.
REQ-042 RST at cycle 6 mid-sweep -> all outputs reset values next cycle; a new start then yields a full normal sweep.

Source files
------------

// File: rtl/prm_sweep_ctrl.sv
// Coordinate sweep controller: walks xyzInput over the full {x,y,z} space, aligns
// the checker's delayed result with the issued coordinate, and tallies hit points.
module prm_sweep_ctrl #(
    parameter int XW  = 4,
    parameter int YW  = 5,
    parameter int ZW  = 5,
    parameter int LAT = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic                    abort,
    input  logic [2:0]              sel1_cfg,
    input  logic [7:0]              sel2_cfg,
    input  logic [31:0]             result_imp,
    output logic [XW+YW+ZW-1:0]     xyzInput,
    output logic [2:0]              sel1,
    output logic [7:0]              sel2,
    output logic                    busy,
    output logic                    done,
    output logic [XW+YW+ZW:0]       hit_cnt,
    output logic [XW+YW+ZW-1:0]     first_hit,
    output logic                    first_hit_vld
);
    localparam int N = XW + YW + ZW;
    localparam logic [N-1:0] XYZ_LAST   = '1;
    localparam logic [N-1:0] XYZ_STEP   = 1;
    localparam logic [N:0]   HIT_STEP   = 1;
    localparam logic [2:0]   DRAIN_LAST = 3'(LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t       state_reg;
    logic [2:0]   drain_cnt_reg;
    logic         tag_vld_reg [LAT];
    logic [N-1:0] tag_xyz_reg [LAT];
    logic         tag_hit;

    // Tag pipeline: each stage carries the coordinate issued gi+1 cycles ago, so
    // the last stage lines up with the checker result for that coordinate.
    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                always_ff @(posedge CLK) begin
                    if (RST || abort) begin
                        tag_vld_reg[gi] <= 1'b0;
                    end else begin
                        tag_vld_reg[gi] <= (state_reg == RUN);
                    end
                    tag_xyz_reg[gi] <= xyzInput;
                end
            end else begin : g_body
                always_ff @(posedge CLK) begin
                    if (RST || abort) begin
                        tag_vld_reg[gi] <= 1'b0;
                    end else begin
                        tag_vld_reg[gi] <= tag_vld_reg[gi-1];
                    end
                    tag_xyz_reg[gi] <= tag_xyz_reg[gi-1];
                end
            end
        end
    endgenerate

    // An abort freezes the tallies at whatever was counted before that edge.
    assign tag_hit = tag_vld_reg[LAT-1] && (result_imp != 32'd0) && !abort;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= 3'd0;
            xyzInput      <= '0;
            sel1          <= 3'd0;
            sel2          <= 8'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hit_cnt       <= '0;
            first_hit     <= '0;
            first_hit_vld <= 1'b0;
        end else begin
            done <= 1'b0;

            if (tag_hit) begin
                hit_cnt <= hit_cnt + HIT_STEP;
                if (!first_hit_vld) begin
                    first_hit     <= tag_xyz_reg[LAT-1];
                    first_hit_vld <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        state_reg     <= RUN;
                        sel1          <= sel1_cfg;
                        sel2          <= sel2_cfg;
                        xyzInput      <= '0;
                        hit_cnt       <= '0;
                        first_hit     <= '0;
                        first_hit_vld <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else if (xyzInput == XYZ_LAST) begin
                        state_reg     <= DRAIN;
                        drain_cnt_reg <= 3'd0;
                    end else begin
                        xyzInput <= xyzInput + XYZ_STEP;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 3'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
